decode_stage_pipe: RTL and testbench
====================================

// Module: decode_stage_pipe
// PURPOSE
//  Parametrised next-generation decode stage for the 5-stage MIPS core: register file, control decode,
//  D->E pipeline register, forwarding-select generation and a load-use interlock FSM.
//  Adds valid/stall/flush/hold handshaking and a configurable data width and register count.
//  Sits between fetch (i_instr/i_pc4) and execute (o_* bundle); jump targets return to the PC mux.
// PARAMETERS
//  XLEN   32  datapath width (>=32); immediates sign/zero-extended to XLEN
//  NREGS  32  architectural registers (power of two, >=8); AW=$clog2(NREGS)
// PORTS
//  i_clk        in   1     clock, all state on posedge
//  i_rst        in   1     reset: one clock domain, synchronous, active-high
//  i_valid      in   1     fetch presents a valid instruction
//  i_instr      in   32    MIPS instruction word
//  i_pc4        in   XLEN  PC+4 of i_instr
//  o_stall      out  1     fetch must hold PC and IF register this cycle
//  i_flush      in   1     branch taken in E: kill instruction entering E
//  i_hold       in   1     downstream back-pressure: freeze D->E register and FSM
//  i_wb_we      in   1     writeback enable
//  i_wb_addr    in   AW    writeback register
//  i_wb_data    in   XLEN  writeback data
//  i_ex_we/i_ex_memread/i_ex_rd   in 1/1/AW  instruction currently in E
//  i_mem_we/i_mem_rd              in 1/AW    instruction currently in M
//  o_valid      out  1     E-stage bundle valid
//  o_rs_data/o_rt_data/o_imm/o_pc4  out XLEN  registered operands, extended immediate, PC+4
//  o_rs/o_rt/o_rd out  AW   registered register addresses
//  o_ctrl       out  ctrl_t registered control struct (aluop, alusrc, regdst, memrd, memwr, loadsel, memtoreg, regwrite, link, bop)
//  o_fa/o_fb    out  2     registered forward selects: 00 regfile, 01 from M, 10 from W
//  o_jump       out  2     combinational: 00 none, 01 j/jal, 10 jr/jalr
//  o_jump_addr  out  XLEN  {i_pc4[XLEN-1:28], instr[25:0], 2'b00}
//  o_jr_data    out  XLEN  rs read value (bypass-aware) for jr
// BEHAVIOUR
//  Reset: all D->E registers, o_valid, o_fa/o_fb = 0; FSM = RUN; register file cleared to 0.
//  Latency: 1 cycle D->E. Register file written on posedge when i_wb_we & i_wb_addr!=0, regardless of hold/stall; r0 reads 0.
//  Update priority each edge: i_rst > i_hold (retain all, FSM frozen) > i_flush (o_valid<=0, o_ctrl<=0, FSM->RUN)
//   > load-use bubble (o_valid<=0, o_ctrl<=0) > capture (o_valid<=i_valid; invalid input captured with o_ctrl=0).
//  hazard = i_valid & i_ex_memread & i_ex_we & i_ex_rd!=0 & (i_ex_rd==rs | (uses_rt & i_ex_rd==rt)), FSM in RUN only.
//  FSM: RUN --hazard & ~hold & ~flush--> LU_STALL (bubble issued); LU_STALL --~hold--> RUN (instruction captured,
//   load is then in M -> o_fa/o_fb=10 at E). Max one bubble per load; hazard ignored in LU_STALL.
//  o_stall = i_hold | (hazard & ~i_flush); flush same cycle as hazard: no stall, flush wins.
//  Forward select per operand: E match (we, rd!=0, rd==src) -> 01; else M match -> 10; else 00. Newer wins on double match.
//  o_jump forced 00 when ~i_valid, o_stall or i_flush. jal/jalr set ctrl.link (rd=31 / rd).
//  Unknown opcode: decoded as NOP (ctrl all zero), o_valid still follows i_valid.
// CONFIGURATION
//  `DEC_WB_BYPASS_EN defined: same-cycle writeback to a read address returns i_wb_data on rs/rt/o_jr_data reads
//   (write-through regfile); forward codes never account for W.
//  Undefined: reads return pre-write contents; W-stage matches produce code 10 relative to the older pipeline
//   (execute mux must select writeback data). Reset, hazard and FSM behaviour identical.
// STRUCTURE
//  Package decode_pkg: opcode/funct localparams, ctrl_t packed struct, fwd_sel_e (FWD_RF/FWD_M/FWD_W), jump_e, lu_state_e.
//  Sub-module decode_ctrl_lut: combinational opcode/funct -> ctrl_t, uses_rt, jump kind, sign-extend select.
//  Register file, forward logic, FSM and pipeline register live in decode_stage_pipe.
// TESTING
//  1 Reset mid-stream: assert i_rst with valid add in D -> next edge o_valid=0, o_ctrl=0, regs read 0.
//  2 lw $2 in E, add $3,$2,$4 in D -> o_stall=1 one cycle, bubble o_valid=0; next edge add captured, o_fa=10.
//  3 add $5 in E and in M, consumer rs=$5 -> o_fa=01 (newer); rs=$0 with E rd=$0 -> o_fa=00.
//  4 i_flush with load-use hazard same cycle -> o_stall=0, o_valid=0, FSM RUN.
//  5 i_hold 3 cycles during LU_STALL -> outputs frozen, single bubble total, WB write of $7=0xDEADBEEF still lands.
//  6 WB $9=0x1234 same cycle as read of $9 -> o_rs_data=0x1234 with DEC_WB_BYPASS_EN, old value without.

Source files
------------

// File: rtl/decode_pkg.sv
// Decode-stage encodings: MIPS opcode/funct values, ALU ops, control bundle and FSM/select enums.
// Shared by decode_ctrl_lut and decode_stage_pipe.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL  = 6'h03, OP_BEQ   = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
                         OP_SLTIU = 6'h0b, OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI  = 6'h0e,
                         OP_LUI   = 6'h0f, OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW    = 6'h23,
                         OP_SB    = 6'h28, OP_SH    = 6'h29, OP_SW   = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08,
                         FN_JALR = 6'h09, FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22,
                         FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26,
                         FN_NOR = 6'h27, FN_SLT = 6'h2a, FN_SLTU = 6'h2b;

  // aluop 0 is reserved for "no operation" so an all-zero ctrl_t is a clean bubble
  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                         ALU_OR  = 4'd4, ALU_XOR = 4'd5, ALU_NOR = 4'd6, ALU_SLT = 4'd7,
                         ALU_SLTU = 4'd8, ALU_SLL = 4'd9, ALU_SRL = 4'd10, ALU_SRA = 4'd11,
                         ALU_LUI = 4'd12;

  localparam logic [1:0] LD_W = 2'd0, LD_B = 2'd1, LD_H = 2'd2;
  localparam logic [1:0] BOP_NONE = 2'd0, BOP_EQ = 2'd1, BOP_NE = 2'd2;

  typedef struct packed {
    logic [3:0] aluop;
    logic       alusrc;
    logic       regdst;
    logic       memrd;
    logic       memwr;
    logic [1:0] loadsel;
    logic       memtoreg;
    logic       regwrite;
    logic       link;
    logic [1:0] bop;
  } ctrl_t;

  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_M = 2'b01, FWD_W = 2'b10} fwd_sel_e;
  typedef enum logic [1:0] {JMP_NONE = 2'b00, JMP_J = 2'b01, JMP_R = 2'b10} jump_e;
  typedef enum logic {LU_RUN = 1'b0, LU_STALL = 1'b1} lu_state_e;

  // The producer now in E reaches M when the consumer reaches E, hence the one-stage shift
  function automatic fwd_sel_e fwd_pick(input logic e_hit, input logic m_hit, input logic w_hit);
    if (e_hit) return FWD_M;
    if (m_hit || w_hit) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/decode_ctrl_lut.sv
// Combinational opcode/funct decode into ctrl_t, rt usage, jump kind and immediate extension.
// Zero latency; unknown encodings decode to an all-zero ctrl_t.
module decode_ctrl_lut
  import decode_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       uses_rt,
  output jump_e      jump_kind,
  output logic       sext
);

  always_comb begin
    ctrl      = '0;
    uses_rt   = 1'b0;
    jump_kind = JMP_NONE;
    sext      = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        uses_rt       = 1'b1;
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.aluop = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.aluop = ALU_SUB;
          FN_AND:  ctrl.aluop = ALU_AND;
          FN_OR:   ctrl.aluop = ALU_OR;
          FN_XOR:  ctrl.aluop = ALU_XOR;
          FN_NOR:  ctrl.aluop = ALU_NOR;
          FN_SLT:  ctrl.aluop = ALU_SLT;
          FN_SLTU: ctrl.aluop = ALU_SLTU;
          FN_SLL:  ctrl.aluop = ALU_SLL;
          FN_SRL:  ctrl.aluop = ALU_SRL;
          FN_SRA:  ctrl.aluop = ALU_SRA;
          FN_JR: begin
            ctrl      = '0;
            uses_rt   = 1'b0;
            jump_kind = JMP_R;
          end
          FN_JALR: begin
            uses_rt   = 1'b0;
            ctrl.link = 1'b1;
            jump_kind = JMP_R;
          end
          default: begin
            ctrl    = '0;
            uses_rt = 1'b0;
          end
        endcase
      end
      OP_J:   jump_kind = JMP_J;
      OP_JAL: begin
        jump_kind     = JMP_J;
        ctrl.link     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        uses_rt    = 1'b1;
        ctrl.aluop = ALU_SUB;
        ctrl.bop   = (opcode == OP_BEQ) ? BOP_EQ : BOP_NE;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        sext          = !(opcode inside {OP_ANDI, OP_ORI, OP_XORI});
        case (opcode)
          OP_SLTI:  ctrl.aluop = ALU_SLT;
          OP_SLTIU: ctrl.aluop = ALU_SLTU;
          OP_ANDI:  ctrl.aluop = ALU_AND;
          OP_ORI:   ctrl.aluop = ALU_OR;
          OP_XORI:  ctrl.aluop = ALU_XOR;
          OP_LUI:   ctrl.aluop = ALU_LUI;
          default:  ctrl.aluop = ALU_ADD;
        endcase
      end
      OP_LB, OP_LH, OP_LW: begin
        ctrl.aluop    = ALU_ADD;
        ctrl.alusrc   = 1'b1;
        ctrl.memrd    = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.loadsel  = (opcode == OP_LB) ? LD_B : (opcode == OP_LH) ? LD_H : LD_W;
      end
      OP_SB, OP_SH, OP_SW: begin
        uses_rt      = 1'b1;
        ctrl.aluop   = ALU_ADD;
        ctrl.alusrc  = 1'b1;
        ctrl.memwr   = 1'b1;
        ctrl.loadsel = (opcode == OP_SB) ? LD_B : (opcode == OP_SH) ? LD_H : LD_W;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: regfile, decode, forward selects, load-use interlock, D->E register (1 cycle).
// i_hold freezes D->E and FSM; o_stall holds fetch. `DEC_WB_BYPASS_EN makes the regfile write-through.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc4,
  output logic            o_stall,
  input  logic            i_flush,
  input  logic            i_hold,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_ex_we,
  input  logic            i_ex_memread,
  input  logic [AW-1:0]   i_ex_rd,
  input  logic            i_mem_we,
  input  logic [AW-1:0]   i_mem_rd,
  output logic            o_valid,
  output logic [XLEN-1:0] o_rs_data,
  output logic [XLEN-1:0] o_rt_data,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_pc4,
  output logic [AW-1:0]   o_rs,
  output logic [AW-1:0]   o_rt,
  output logic [AW-1:0]   o_rd,
  output ctrl_t           o_ctrl,
  output logic [1:0]      o_fa,
  output logic [1:0]      o_fb,
  output logic [1:0]      o_jump,
  output logic [XLEN-1:0] o_jump_addr,
  output logic [XLEN-1:0] o_jr_data
);

  ctrl_t           ctrl;
  jump_e           jump_kind;
  logic            uses_rt, sext;
  logic [AW-1:0]   rs, rt, rd_dst;
  logic [XLEN-1:0] imm_ext, rs_val, rt_val;
  logic [XLEN-1:0] rf [NREGS];
  logic            wb_rs_hit, wb_rt_hit, w_rs_fwd, w_rt_fwd;
  fwd_sel_e        fa_nxt, fb_nxt;
  logic            hazard, bubble;
  lu_state_e       state, state_nxt;

  decode_ctrl_lut u_lut (
    .opcode    (i_instr[31:26]),
    .funct     (i_instr[5:0]),
    .ctrl      (ctrl),
    .uses_rt   (uses_rt),
    .jump_kind (jump_kind),
    .sext      (sext)
  );

  assign rs      = AW'(i_instr[25:21]);
  assign rt      = AW'(i_instr[20:16]);
  assign rd_dst  = (jump_kind == JMP_J && ctrl.link) ? AW'(5'd31) : AW'(i_instr[15:11]);
  assign imm_ext = sext ? {{(XLEN-16){i_instr[15]}}, i_instr[15:0]} : {{(XLEN-16){1'b0}}, i_instr[15:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (i_wb_we && i_wb_addr != '0) begin
      rf[i_wb_addr] <= i_wb_data;
    end
  end

  assign wb_rs_hit = i_wb_we && (i_wb_addr != '0) && (i_wb_addr == rs);
  assign wb_rt_hit = i_wb_we && (i_wb_addr != '0) && (i_wb_addr == rt);

  always_comb begin
    rs_val = (rs == '0) ? '0 : rf[rs];
    rt_val = (rt == '0) ? '0 : rf[rt];
`ifdef DEC_WB_BYPASS_EN
    if (wb_rs_hit) rs_val = i_wb_data;
    if (wb_rt_hit) rt_val = i_wb_data;
`endif
  end

  // Without the write-through path, a same-cycle W write is picked up by the execute mux instead
`ifdef DEC_WB_BYPASS_EN
  assign w_rs_fwd = 1'b0;
  assign w_rt_fwd = 1'b0;
`else
  assign w_rs_fwd = wb_rs_hit;
  assign w_rt_fwd = wb_rt_hit;
`endif

  assign fa_nxt = fwd_pick(i_ex_we && i_ex_rd != '0 && i_ex_rd == rs,
                           i_mem_we && i_mem_rd != '0 && i_mem_rd == rs, w_rs_fwd);
  assign fb_nxt = fwd_pick(i_ex_we && i_ex_rd != '0 && i_ex_rd == rt,
                           i_mem_we && i_mem_rd != '0 && i_mem_rd == rt, w_rt_fwd);

  assign hazard = i_valid && (state == LU_RUN) && i_ex_memread && i_ex_we && (i_ex_rd != '0) &&
                  ((i_ex_rd == rs) || (uses_rt && i_ex_rd == rt));
  assign o_stall = i_hold || (hazard && !i_flush);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= LU_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bubble    = 1'b0;
    case (state)
      LU_RUN: begin
        if (hazard && !i_hold && !i_flush) begin
          bubble    = 1'b1;
          state_nxt = LU_STALL;
        end
      end
      LU_STALL: if (!i_hold) state_nxt = LU_RUN;
      default:  state_nxt = LU_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_ctrl    <= '0;
      o_rs_data <= '0;
      o_rt_data <= '0;
      o_imm     <= '0;
      o_pc4     <= '0;
      o_rs      <= '0;
      o_rt      <= '0;
      o_rd      <= '0;
      o_fa      <= FWD_RF;
      o_fb      <= FWD_RF;
    end else if (!i_hold) begin
      if (i_flush || bubble) begin
        o_valid <= 1'b0;
        o_ctrl  <= '0;
      end else begin
        o_valid   <= i_valid;
        o_ctrl    <= i_valid ? ctrl : '0;
        o_rs_data <= rs_val;
        o_rt_data <= rt_val;
        o_imm     <= imm_ext;
        o_pc4     <= i_pc4;
        o_rs      <= rs;
        o_rt      <= rt;
        o_rd      <= rd_dst;
        o_fa      <= fa_nxt;
        o_fb      <= fb_nxt;
      end
    end
  end

  assign o_jump      = (i_valid && !o_stall && !i_flush) ? jump_kind : JMP_NONE;
  assign o_jump_addr = {i_pc4[XLEN-1:28], i_instr[25:0], 2'b00};
  assign o_jr_data   = rs_val;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed-vector scoreboard bench for decode_stage_pipe (XLEN=32, NREGS=32).
// Stimulus pushes expected E bundles; a negedge monitor pops them on each captured valid output.
module tb_decode_stage_pipe;
  import decode_pkg::*;

  logic        i_clk, i_rst, i_valid, i_flush, i_hold;
  logic [31:0] i_instr, i_pc4, i_wb_data;
  logic        i_wb_we, i_ex_we, i_ex_memread, i_mem_we;
  logic [4:0]  i_wb_addr, i_ex_rd, i_mem_rd;
  logic        o_stall, o_valid;
  logic [31:0] o_rs_data, o_rt_data, o_imm, o_pc4, o_jump_addr, o_jr_data;
  logic [4:0]  o_rs, o_rt, o_rd;
  ctrl_t       o_ctrl;
  logic [1:0]  o_fa, o_fb, o_jump;

  decode_stage_pipe #(.XLEN(32), .NREGS(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc4(i_pc4),
    .o_stall(o_stall), .i_flush(i_flush), .i_hold(i_hold),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_ex_we(i_ex_we), .i_ex_memread(i_ex_memread), .i_ex_rd(i_ex_rd),
    .i_mem_we(i_mem_we), .i_mem_rd(i_mem_rd),
    .o_valid(o_valid), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm), .o_pc4(o_pc4),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_ctrl(o_ctrl), .o_fa(o_fa), .o_fb(o_fb),
    .o_jump(o_jump), .o_jump_addr(o_jump_addr), .o_jr_data(o_jr_data)
  );

`ifdef DEC_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [1:0]  fa;
    logic [1:0]  fb;
    ctrl_t       ctrl;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  logic  cap_q = 1'b0;
  ctrl_t c_add, c_addi, c_ori, c_jal;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // An edge updates the D->E register only when neither reset nor hold was applied to it
  always @(posedge i_clk) cap_q <= !i_rst && !i_hold;

  always @(negedge i_clk) begin
    exp_t act, e;
    string nm;
    if (cap_q && o_valid) begin
      act = {o_rs_data, o_rt_data, o_imm, o_rd, o_fa, o_fb, o_ctrl};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got bundle %h with nothing expected", act);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  function automatic ctrl_t mkc(input logic [3:0] aluop, input logic alusrc, input logic regdst,
                                input logic regwrite, input logic link);
    ctrl_t c;
    c          = '0;
    c.aluop    = aluop;
    c.alusrc   = alusrc;
    c.regdst   = regdst;
    c.regwrite = regwrite;
    c.link     = link;
    return c;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] rs_d, input logic [31:0] rt_d,
                      input logic [31:0] imm, input logic [4:0] rd, input logic [1:0] fa,
                      input logic [1:0] fb, input ctrl_t c);
    exp_q.push_back({rs_d, rt_d, imm, rd, fa, fb, c});
    name_q.push_back(nm);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    tick();
    i_wb_we = 1'b0;
  endtask

  localparam logic [31:0] ADD_3_2_4 = 32'h00441820;

  initial begin
    c_add  = mkc(ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    c_addi = mkc(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
    c_ori  = mkc(ALU_OR,  1'b1, 1'b0, 1'b1, 1'b0);
    c_jal  = mkc(ALU_NOP, 1'b0, 1'b0, 1'b1, 1'b1);
    i_rst = 1'b1; i_valid = 1'b0; i_instr = '0; i_pc4 = 32'h0040_0010;
    i_flush = 1'b0; i_hold = 1'b0; i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0;
    i_ex_we = 1'b0; i_ex_memread = 1'b0; i_ex_rd = '0; i_mem_we = 1'b0; i_mem_rd = '0;
    tick(); tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ctrl", 64'(o_ctrl), 64'd0);
    chk("rst_fwd", 64'({o_fa, o_fb}), 64'd0);
    i_rst = 1'b0;
    wr(5'd2, 32'h22); wr(5'd4, 32'h44);

    // reset arriving with a valid instruction in D, then register file reads back as zero
    i_valid = 1'b1; i_instr = ADD_3_2_4; i_rst = 1'b1;
    tick();
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_ctrl", 64'(o_ctrl), 64'd0);
    i_rst = 1'b0;
    push("rst_regs_zero", 32'h0, 32'h0, 32'h1820, 5'd3, 2'b00, 2'b00, c_add);
    tick();
    i_valid = 1'b0;
    wr(5'd2, 32'h22); wr(5'd4, 32'h44); wr(5'd5, 32'h55); wr(5'd9, 32'h99);

    // plain decode of several formats
    i_valid = 1'b1;
    i_instr = ADD_3_2_4;    push("add", 32'h22, 32'h44, 32'h1820, 5'd3, 2'b00, 2'b00, c_add); tick();
    i_instr = 32'h208BFFFF; push("addi_sext", 32'h44, 32'h0, 32'hFFFFFFFF, 5'd31, 2'b00, 2'b00, c_addi); tick();
    i_instr = 32'h340C8001; push("ori_zext", 32'h0, 32'h0, 32'h00008001, 5'd16, 2'b00, 2'b00, c_ori); tick();
    i_instr = 32'h0C000100; #1;
    chk("jal_kind", 64'(o_jump), 64'd1);
    chk("jal_addr", 64'(o_jump_addr), 64'h0000_0400);
    push("jal", 32'h0, 32'h0, 32'h100, 5'd31, 2'b00, 2'b00, c_jal); tick();
    i_instr = 32'h00A00008; #1;
    chk("jr_kind", 64'(o_jump), 64'd2);
    chk("jr_data", 64'(o_jr_data), 64'h55);
    push("jr", 32'h55, 32'h0, 32'h8, 5'd0, 2'b00, 2'b00, '0); tick();
    i_instr = 32'hFC000000; push("unknown_nop", 32'h0, 32'h0, 32'h0, 5'd0, 2'b00, 2'b00, '0); tick();
    i_instr = 32'h0C000100; i_flush = 1'b1; #1;
    chk("flush_jump", 64'(o_jump), 64'd0);
    tick();
    chk("flush_valid", 64'(o_valid), 64'd0);
    i_flush = 1'b0; i_valid = 1'b0; #1;
    chk("invalid_jump", 64'(o_jump), 64'd0);
    i_valid = 1'b1;

    // forwarding: E and M both match (E wins), then r0 never forwards
    i_ex_we = 1'b1; i_ex_rd = 5'd5; i_mem_we = 1'b1; i_mem_rd = 5'd5; i_instr = 32'h00A03020;
    push("fwd_newer", 32'h55, 32'h0, 32'h3020, 5'd6, 2'b01, 2'b00, c_add); tick();
    i_ex_rd = 5'd0; i_mem_rd = 5'd0; i_instr = 32'h00014020;
    push("fwd_r0", 32'h0, 32'h0, 32'h4020, 5'd8, 2'b00, 2'b00, c_add); tick();
    i_ex_we = 1'b0; i_mem_we = 1'b0;

    // flush coinciding with load-use: flush wins, FSM stays in RUN so the hazard stalls next cycle
    i_ex_we = 1'b1; i_ex_memread = 1'b1; i_ex_rd = 5'd2; i_instr = ADD_3_2_4; i_flush = 1'b1; #1;
    chk("flush_hz_stall", 64'(o_stall), 64'd0);
    tick();
    chk("flush_hz_valid", 64'(o_valid), 64'd0);
    chk("flush_hz_ctrl", 64'(o_ctrl), 64'd0);
    i_flush = 1'b0; #1;
    chk("lu_stall", 64'(o_stall), 64'd1);
    tick();
    chk("lu_bubble", 64'(o_valid), 64'd0);
    i_ex_we = 1'b0; i_ex_memread = 1'b0; i_ex_rd = '0; i_mem_we = 1'b1; i_mem_rd = 5'd2; #1;
    chk("lu_release", 64'(o_stall), 64'd0);
    push("lu_fwd_m", 32'h22, 32'h44, 32'h1820, 5'd3, 2'b10, 2'b00, c_add); tick();

    // load-use on rt, then three held cycles in LU_STALL with a writeback landing meanwhile
    i_mem_we = 1'b0; i_mem_rd = '0; i_ex_we = 1'b1; i_ex_memread = 1'b1; i_ex_rd = 5'd4; #1;
    chk("lu2_stall", 64'(o_stall), 64'd1);
    tick();
    chk("lu2_bubble", 64'(o_valid), 64'd0);
    i_ex_we = 1'b0; i_ex_memread = 1'b0; i_ex_rd = '0; i_mem_we = 1'b1; i_mem_rd = 5'd4;
    i_hold = 1'b1; i_wb_we = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_stall", 64'(o_stall), 64'd1);
      tick();
      chk("hold_valid", 64'(o_valid), 64'd0);
    end
    i_hold = 1'b0; i_wb_we = 1'b0; #1;
    chk("hold_release", 64'(o_stall), 64'd0);
    push("lu_hold_fwd", 32'h22, 32'h44, 32'h1820, 5'd3, 2'b00, 2'b10, c_add); tick();
    i_mem_we = 1'b0; i_mem_rd = '0;
    i_instr = 32'h00E06820;
    push("wb_during_hold", 32'hDEADBEEF, 32'h0, 32'h6820, 5'd13, 2'b00, 2'b00, c_add); tick();

    // writeback and read of the same register in one cycle
    i_wb_we = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'h1234; i_instr = 32'h01205020;
    push("wb_same_cycle", BYP ? 32'h1234 : 32'h99, 32'h0, 32'h5020, 5'd10,
         BYP ? 2'b00 : 2'b10, 2'b00, c_add);
    tick();
    i_wb_we = 1'b0;
    push("wb_after", 32'h1234, 32'h0, 32'h5020, 5'd10, 2'b00, 2'b00, c_add); tick();
    i_valid = 1'b0;
    tick(); tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
